// File: rtl/ikbd_input_arbiter.sv
// ikbd input arbiter: synchronises and debounces NCH input sources of W bits.
// It routes the most recently active source onto the shared 6301 port lines.
// A hold-off follows every switch, a forced-lock mode overrides activity,
// and a one-cycle strobe marks each change of the active channel.
module ikbd_input_arbiter #(
  parameter  int NCH         = 2,
  parameter  int W           = 6,
  parameter  int SYNC_STAGES = 2,
  parameter  int DEB_CYC     = 4,
  parameter  int HOLD_CYC    = 1000,
  parameter  int DEF_CH      = 0,
  localparam int CW          = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              res,
  input  logic [NCH*W-1:0]  src,
  input  logic              lock,
  input  logic [CW-1:0]     lock_sel,
  output logic [W-1:0]      out,
  output logic [CW-1:0]     active_ch,
  output logic              switch_pulse,
  output logic [NCH*W-1:0]  deb_all
);

  localparam int CNTW = $clog2(DEB_CYC) + 1;
  localparam int HW   = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  typedef enum logic [1:0] {S_RUN, S_HOLD, S_LOCK} state_t;

  logic [NCH*W-1:0] w_raw;
  logic [NCH*W-1:0] r_deb;
  logic [CNTW-1:0]  r_cnt [NCH];
  logic [NCH-1:0]   w_chg;

  state_t           r_state, w_state_nx;
  logic [HW-1:0]    r_hold, w_hold_nx;
  logic [CW-1:0]    r_active, w_active_nx;
  logic             r_pulse, w_pulse_nx;
  logic [CW-1:0]    w_target;
  logic [CW-1:0]    w_cand;
  logic             w_cand_vld;

  // Synchroniser chain per source bit; bypassed when sources are already in the clk domain.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_raw = src;
    end else begin : g_sync
      logic [NCH*W-1:0] r_sync [SYNC_STAGES];
      // Shift every source bit through the synchroniser stages.
      always_ff @(posedge clk or negedge res) begin
        if (!res) begin
          // NOTE: register arrays are reset element by element; they are flops, not RAM, so clearing them is free of macro constraints.
          for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
        end else begin
          // NOTE: non-blocking assignments let each stage capture the previous stage's old value, forming a real shift chain.
          r_sync[0] <= src;
          for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
        end
      end
      assign w_raw = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  // Flag channels whose differing raw value has now been stable long enough to accept.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    w_chg = '0;
    for (int i = 0; i < NCH; i++) begin
      w_chg[i] = (w_raw[i*W +: W] != r_deb[i*W +: W]) && (r_cnt[i] == CNTW'(DEB_CYC - 1));
    end
  end

  // Per-channel debounce: count cycles of disagreement, and restart on any return to the accepted value.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_deb <= '0;
      for (int i = 0; i < NCH; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (w_raw[i*W +: W] == r_deb[i*W +: W]) begin
          r_cnt[i] <= '0;
        end else if (w_chg[i]) begin
          r_deb[i*W +: W] <= w_raw[i*W +: W];
          r_cnt[i]        <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNTW'(1);
        end
      end
    end
  end

  // Pick the lock target and the lowest-index newly active channel other than the current one.
  always_comb begin
    w_target   = (32'(lock_sel) < NCH) ? lock_sel : '0;
    w_cand     = '0;
    w_cand_vld = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (w_chg[i] && (CW'(i) != r_active)) begin
        w_cand     = CW'(i);
        w_cand_vld = 1'b1;
      end
    end
  end

  // Arbiter next-state: lock overrides everything; RUN switches on activity; HOLD waits out the hold-off.
  always_comb begin
    w_state_nx  = r_state;
    w_hold_nx   = r_hold;
    w_active_nx = r_active;
    w_pulse_nx  = 1'b0;
    if (lock) begin
      w_state_nx = S_LOCK;
      w_hold_nx  = '0;
      if (w_target != r_active) begin
        w_active_nx = w_target;
        w_pulse_nx  = 1'b1;
      end
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_cand_vld) begin
            w_active_nx = w_cand;
            w_pulse_nx  = 1'b1;
            if (HOLD_CYC > 0) begin
              w_hold_nx  = HW'(HOLD_CYC - 1);
              w_state_nx = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (r_hold == '0) w_state_nx = S_RUN;
          else              w_hold_nx  = r_hold - HW'(1);
        end
        S_LOCK: begin
          w_state_nx = S_RUN;
          w_hold_nx  = '0;
        end
        default: w_state_nx = S_RUN;
      endcase
    end
  end

  // Arbiter state register.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state  <= S_RUN;
      r_hold   <= '0;
      r_active <= CW'(DEF_CH);
      r_pulse  <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_hold   <= w_hold_nx;
      r_active <= w_active_nx;
      r_pulse  <= w_pulse_nx;
    end
  end

  // Route the debounced value of the active channel; inactive channels never contribute.
  always_comb begin
    out = '0;
    for (int i = 0; i < NCH; i++) begin
      if (r_active == CW'(i)) out = r_deb[i*W +: W];
    end
  end

  assign active_ch    = r_active;
  assign switch_pulse = r_pulse;
  assign deb_all      = r_deb;

endmodule

// File: tb/tb_ikbd_input_arbiter.sv
// Bench for ikbd_input_arbiter: directed stimulus with hand-computed literals,
// plus a cycle-level behavioural model compared against the DUT on every falling edge.
// NCH=5 so lock_sel is 3 bits wide and the value 7 is out of range.
module tb_ikbd_input_arbiter;

  localparam int NCH      = 5;
  localparam int W        = 6;
  localparam int SYNC     = 2;
  localparam int DEB_CYC  = 4;
  localparam int HOLD_CYC = 1000;
  localparam int DEF_CH   = 0;
  localparam int CW       = 3;

  logic              clk = 1'b0;
  logic              res;
  logic [NCH*W-1:0]  src;
  logic              lock;
  logic [CW-1:0]     lock_sel;
  logic [W-1:0]      out;
  logic [CW-1:0]     active_ch;
  logic              switch_pulse;
  logic [NCH*W-1:0]  deb_all;

  int total = 0;
  int bad   = 0;

  ikbd_input_arbiter #(
    .NCH(NCH), .W(W), .SYNC_STAGES(SYNC), .DEB_CYC(DEB_CYC),
    .HOLD_CYC(HOLD_CYC), .DEF_CH(DEF_CH)
  ) dut (
    .clk(clk), .res(res), .src(src), .lock(lock), .lock_sel(lock_sel),
    .out(out), .active_ch(active_ch), .switch_pulse(switch_pulse), .deb_all(deb_all)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_pipe [SYNC][NCH];
  logic [W-1:0] m_deb  [NCH];
  int           m_run  [NCH];     // consecutive cycles raw has disagreed with accepted value
  int           m_active;
  int           m_hold_left;      // switch-suppressed cycles still to come
  bit           m_locked;
  bit           m_pulse;

  always @(posedge clk or negedge res) begin
    bit           acc [NCH];
    logic [W-1:0] raw;
    int           cand;
    int           tgt;
    if (!res) begin
      for (int s = 0; s < SYNC; s++)
        for (int c = 0; c < NCH; c++) m_pipe[s][c] <= '0;
      for (int c = 0; c < NCH; c++) begin
        m_deb[c] <= '0;
        m_run[c] <= 0;
      end
      m_active    <= DEF_CH;
      m_pulse     <= 1'b0;
      m_hold_left <= 0;
      m_locked    <= 1'b0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        raw    = m_pipe[SYNC-1][c];
        acc[c] = 1'b0;
        if (raw == m_deb[c]) m_run[c] <= 0;
        else if (m_run[c] + 1 >= DEB_CYC) begin
          m_deb[c] <= raw;
          m_run[c] <= 0;
          acc[c]   = 1'b1;
        end else m_run[c] <= m_run[c] + 1;
        m_pipe[0][c] <= src[c*W +: W];
        for (int s = 1; s < SYNC; s++) m_pipe[s][c] <= m_pipe[s-1][c];
      end
      if (lock) begin
        tgt = (int'(lock_sel) < NCH) ? int'(lock_sel) : 0;
        m_pulse     <= (tgt != m_active);
        m_active    <= tgt;
        m_locked    <= 1'b1;
        m_hold_left <= 0;
      end else if (m_locked) begin
        m_locked <= 1'b0;
        m_pulse  <= 1'b0;
      end else if (m_hold_left > 0) begin
        m_hold_left <= m_hold_left - 1;
        m_pulse     <= 1'b0;
      end else begin
        cand = -1;
        for (int c = 0; c < NCH; c++)
          if (acc[c] && c != m_active && cand < 0) cand = c;
        if (cand >= 0) begin
          m_active    <= cand;
          m_pulse     <= 1'b1;
          m_hold_left <= HOLD_CYC;
        end else m_pulse <= 1'b0;
      end
    end
  end

  function automatic logic [NCH*W-1:0] model_deb_all();
    logic [NCH*W-1:0] v;
    for (int c = 0; c < NCH; c++) v[c*W +: W] = m_deb[c];
    return v;
  endfunction

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    check("cyc_out",     64'(out),          64'(m_deb[m_active]));
    check("cyc_active",  64'(active_ch),    64'(m_active));
    check("cyc_pulse",   64'(switch_pulse), 64'(m_pulse));
    check("cyc_deb_all", 64'(deb_all),      64'(model_deb_all()));
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ch(input int ch, input logic [W-1:0] v);
    src[ch*W +: W] = v;
  endtask

  initial begin
    res = 1'b1; src = '0; lock = 1'b0; lock_sel = '0;
    #3 res = 1'b0;
    tick(3);
    res = 1'b1;
    check("rst_active", 64'(active_ch), 64'd0);
    check("rst_out",    64'(out),       64'd0);
    check("rst_pulse",  64'(switch_pulse), 64'd0);

    // Three-cycle glitch on ch0 is filtered out.
    tick(2);
    set_ch(0, 6'h01); tick(3);
    set_ch(0, 6'h00); tick(8);
    check("glitch_out", 64'(out), 64'd0);

    // Stable change lands exactly six edges later.
    set_ch(0, 6'h01); tick(5);
    check("lat_before", 64'(out), 64'd0);
    tick(1);
    check("lat_at6", 64'(out), 64'h01);
    check("lat_nopulse", 64'(switch_pulse), 64'd0);

    // Switch to ch1, then a ch0 change inside the hold-off is ignored.
    set_ch(1, 6'h04); tick(6);
    check("sw1_active", 64'(active_ch), 64'd1);
    check("sw1_pulse",  64'(switch_pulse), 64'd1);
    check("sw1_out",    64'(out), 64'h04);
    tick(1);
    check("sw1_pulse_end", 64'(switch_pulse), 64'd0);
    set_ch(0, 6'h00); tick(20);
    check("hold_active", 64'(active_ch), 64'd1);
    check("hold_out",    64'(out), 64'h04);
    tick(1000);
    set_ch(0, 6'h02); tick(6);
    check("post_hold_active", 64'(active_ch), 64'd0);
    check("post_hold_pulse",  64'(switch_pulse), 64'd1);
    check("post_hold_out",    64'(out), 64'h02);

    // Changes on the active channel alone: out follows, no pulse.
    for (int k = 0; k < 4; k++) begin
      set_ch(0, (k % 2 == 0) ? 6'h03 : 6'h02);
      tick(6);
      check("self_out",   64'(out), (k % 2 == 0) ? 64'h03 : 64'h02);
      check("self_pulse", 64'(switch_pulse), 64'd0);
    end
    tick(1000);

    // ch3 and ch2 accepted on the same cycle: lowest index wins.
    set_ch(3, 6'h08); set_ch(2, 6'h01); tick(6);
    check("simul_active", 64'(active_ch), 64'd2);
    check("simul_pulse",  64'(switch_pulse), 64'd1);
    check("simul_out",    64'(out), 64'h01);
    tick(1);
    check("simul_pulse_end", 64'(switch_pulse), 64'd0);
    tick(1000);

    // Forced lock.
    lock = 1'b1; lock_sel = 3'd3; tick(1);
    check("lock_active", 64'(active_ch), 64'd3);
    check("lock_pulse",  64'(switch_pulse), 64'd1);
    check("lock_out",    64'(out), 64'h08);
    tick(1);
    set_ch(1, 6'h05); tick(8);
    check("lock_ignore", 64'(active_ch), 64'd3);
    lock_sel = 3'd7; tick(1);
    check("lock_oor_active", 64'(active_ch), 64'd0);
    check("lock_oor_pulse",  64'(switch_pulse), 64'd1);
    tick(1);
    lock = 1'b0; tick(1);
    check("unlock_pulse",  64'(switch_pulse), 64'd0);
    check("unlock_active", 64'(active_ch), 64'd0);
    tick(2);
    set_ch(1, 6'h06); tick(6);
    check("unlock_sw_active", 64'(active_ch), 64'd1);
    check("unlock_sw_pulse",  64'(switch_pulse), 64'd1);
    check("unlock_sw_out",    64'(out), 64'h06);

    // Asynchronous reset in the middle of the hold-off.
    tick(10);
    #2 res = 1'b0;
    #1;
    check("arst_active", 64'(active_ch), 64'd0);
    check("arst_pulse",  64'(switch_pulse), 64'd0);
    check("arst_out",    64'(out), 64'd0);
    src = '0;
    tick(3);
    res = 1'b1;
    tick(10);
    set_ch(2, 6'h03); tick(6);
    check("arst_sw_active", 64'(active_ch), 64'd2);
    check("arst_sw_pulse",  64'(switch_pulse), 64'd1);
    check("arst_sw_out",    64'(out), 64'h03);
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
